spi_mem_ctrl: RTL and testbench

Bit-serial SPI memory controller between the rv32e core's load/store/fetch port and the external SPI flash (code) and SPI RAM (data) on the `uio` pins of `tt_um_rv32e_cpu`. It accepts one byte, halfword or word request at a time and runs a complete SPI mode-0 transaction at clk/2. It then returns read data, assembled little-endian, with a one-cycle response strobe.

---
 rtl/spi_mem_pkg.sv | 59 +++++
 rtl/spi_mem_ctrl_if.sv | 23 ++
 rtl/spi_shift_engine.sv | 69 ++++++
 rtl/spi_mem_ctrl.sv | 167 ++++++++++++++++
 tb/tb_spi_mem_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_mem_pkg.sv
// Shared types, opcodes and bit counts for the SPI memory controller.
// Optional fast-read support is selected with SPI_FAST_READ_EN.
package spi_mem_pkg;

  localparam int ADDR_W = 24;

`ifdef SPI_FAST_READ_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } state_t;
`endif

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_WRITE     = 8'h02;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [5:0] CMD_BITS   = 6'd8;
  localparam logic [5:0] ADDR_BITS  = 6'd24;
  localparam logic [5:0] DUMMY_BITS = 6'd8;

  function automatic logic [31:0] bswap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic logic [5:0] data_bits(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 6'd8;
      SZ_HALF: return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

  // Serial capture holds the first byte highest; flip it back to little-endian.
  function automatic logic [31:0] assemble_rdata(input logic [31:0] rx, input logic [1:0] size);
    case (size)
      SZ_BYTE: return {24'h0, rx[7:0]};
      SZ_HALF: return {16'h0, rx[7:0], rx[15:8]};
      default: return bswap32(rx);
    endcase
  endfunction

endpackage

// File: rtl/spi_mem_ctrl_if.sv
// Request/response bus between the core memory port and spi_mem_ctrl.
interface spi_mem_ctrl_if;
  logic                          req_valid;
  logic                          req_ready;
  logic                          req_write;
  logic                          req_sel;
  logic [1:0]                    req_size;
  logic [spi_mem_pkg::ADDR_W-1:0] req_addr;
  logic [31:0]                   req_wdata;
  logic                          resp_valid;
  logic [31:0]                   resp_rdata;
  logic                          resp_err;

  modport master (
    output req_valid, req_write, req_sel, req_size, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_sel, req_size, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/spi_shift_engine.sv
// Bit-slot engine: two-phase SCLK generation, MOSI shifting (MSB first) and MISO capture.
module spi_shift_engine (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [31:0] i_data,
  input  logic [5:0]  i_nbits,
  input  logic        i_miso,
  output logic        o_sclk,
  output logic        o_mosi,
  output logic        o_done,
  output logic [31:0] o_rx_next
);

  logic        r_active;
  logic        r_phase;
  logic        r_sclk;
  logic        r_mosi;
  logic [4:0]  r_cnt;
  logic [31:0] r_shift;
  logic [31:0] r_rx;
  logic [31:0] w_rx_next;

  assign w_rx_next = {r_rx[30:0], i_miso};
  assign o_rx_next = w_rx_next;
  assign o_done    = r_active && r_phase && (r_cnt == 5'd0);
  assign o_sclk    = r_sclk;
  assign o_mosi    = r_mosi;

  // A load on the final phase-1 edge starts the next segment with no gap slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= 1'b0;
      r_phase  <= 1'b0;
      r_sclk   <= 1'b0;
      r_mosi   <= 1'b0;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_rx     <= '0;
    end else begin
      if (r_active && r_phase) r_rx <= w_rx_next;
      if (i_load) begin
        r_active <= 1'b1;
        r_phase  <= 1'b0;
        r_sclk   <= 1'b0;
        r_mosi   <= i_data[31];
        r_shift  <= {i_data[30:0], 1'b0};
        r_cnt    <= 5'(i_nbits - 6'd1);
      end else if (r_active) begin
        if (!r_phase) begin
          r_phase <= 1'b1;
          r_sclk  <= 1'b1;
        end else begin
          r_phase <= 1'b0;
          r_sclk  <= 1'b0;
          if (r_cnt == 5'd0) begin
            r_active <= 1'b0;
            r_mosi   <= 1'b0;
          end else begin
            r_cnt   <= r_cnt - 5'd1;
            r_mosi  <= r_shift[31];
            r_shift <= {r_shift[30:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: rtl/spi_mem_ctrl.sv
// SPI mode-0 memory controller: flash on cs0_n, RAM on cs1_n, SCLK at clk/2.
// Define SPI_FAST_READ_EN for 0x0B reads with an 8-bit dummy phase.
module spi_mem_ctrl
  import spi_mem_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  spi_mem_ctrl_if.slave  bus,
  input  logic           i_spi_miso,
  output logic           o_spi_sclk,
  output logic           o_spi_mosi,
  output logic           o_spi_cs0_n,
  output logic           o_spi_cs1_n
);

`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] READ_OPCODE = OP_FAST_READ;
`else
  localparam logic [7:0] READ_OPCODE = OP_READ;
`endif

  state_t              r_state;
  logic                r_write;
  logic                r_sel;
  logic [1:0]          r_size;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;
  logic                r_err;
  logic                r_cs0_n;
  logic                r_cs1_n;

  state_t              w_next;
  logic                w_load;
  logic [31:0]         w_ld_data;
  logic [5:0]          w_ld_bits;
  logic                w_done;
  logic [31:0]         w_rx_next;
  logic                w_accept;
  logic                w_reject;
  logic                w_sel;
  logic                w_spi_next;
  logic [31:0]         w_data_word;
  logic [5:0]          w_data_bits;

  assign w_accept    = (r_state == ST_IDLE) && bus.req_valid;
  assign w_reject    = w_accept && bus.req_write && !bus.req_sel;
  assign w_sel       = w_accept ? bus.req_sel : r_sel;
  assign w_spi_next  = (w_next != ST_IDLE) && (w_next != ST_DONE);
  assign w_data_word = r_write ? bswap32(r_wdata) : 32'h0;
  assign w_data_bits = data_bits(r_size);

  spi_shift_engine u_engine (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_data    (w_ld_data),
    .i_nbits   (w_ld_bits),
    .i_miso    (i_spi_miso),
    .o_sclk    (o_spi_sclk),
    .o_mosi    (o_spi_mosi),
    .o_done    (w_done),
    .o_rx_next (w_rx_next)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Each segment's engine load is issued on the edge that leaves the previous state.
  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_ld_data = '0;
    w_ld_bits = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_reject) begin
          w_next = ST_DONE;
        end else if (w_accept) begin
          w_next    = ST_CMD;
          w_load    = 1'b1;
          w_ld_data = {(bus.req_write ? OP_WRITE : READ_OPCODE), 24'h0};
          w_ld_bits = CMD_BITS;
        end
      end
      ST_CMD: begin
        if (w_done) begin
          w_next    = ST_ADDR;
          w_load    = 1'b1;
          w_ld_data = {r_addr, 8'h00};
          w_ld_bits = ADDR_BITS;
        end
      end
      ST_ADDR: begin
        if (w_done) begin
`ifdef SPI_FAST_READ_EN
          if (!r_write) begin
            w_next    = ST_DUMMY;
            w_load    = 1'b1;
            w_ld_data = '0;
            w_ld_bits = DUMMY_BITS;
          end else
`endif
          begin
            w_next    = ST_DATA;
            w_load    = 1'b1;
            w_ld_data = w_data_word;
            w_ld_bits = w_data_bits;
          end
        end
      end
`ifdef SPI_FAST_READ_EN
      ST_DUMMY: begin
        if (w_done) begin
          w_next    = ST_DATA;
          w_load    = 1'b1;
          w_ld_data = w_data_word;
          w_ld_bits = w_data_bits;
        end
      end
`endif
      ST_DATA: begin
        if (w_done) w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_write <= 1'b0;
      r_sel   <= 1'b0;
      r_size  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cs0_n <= 1'b1;
      r_cs1_n <= 1'b1;
    end else begin
      r_cs0_n <= !(w_spi_next && !w_sel);
      r_cs1_n <= !(w_spi_next && w_sel);
      if (w_accept) begin
        r_write <= bus.req_write;
        r_sel   <= bus.req_sel;
        r_size  <= bus.req_size;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_rdata <= '0;
        r_err   <= w_reject;
      end else if ((r_state == ST_DATA) && w_done && !r_write) begin
        r_rdata <= assemble_rdata(w_rx_next, r_size);
      end
    end
  end

  assign bus.req_ready  = (r_state == ST_IDLE);
  assign bus.resp_valid = (r_state == ST_DONE);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;
  assign o_spi_cs0_n    = r_cs0_n;
  assign o_spi_cs1_n    = r_cs1_n;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Self-checking bench for spi_mem_ctrl: directed table, SPI slave model, random requests.
module tb_spi_mem_ctrl;

`ifdef SPI_FAST_READ_EN
  localparam int FAST = 1;
`else
  localparam int FAST = 0;
`endif
  localparam int F16 = FAST * 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic miso = 1'b0;
  logic sclk, mosi, cs0n, cs1n;

  spi_mem_ctrl_if bus();

  spi_mem_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .i_spi_miso  (miso),
    .o_spi_sclk  (sclk),
    .o_spi_mosi  (mosi),
    .o_spi_cs0_n (cs0n),
    .o_spi_cs1_n (cs1n)
  );

  always #5 clk = ~clk;

  typedef struct {
    string     name;
    bit        write;
    bit        sel;
    bit [1:0]  size;
    bit [23:0] addr;
    bit [31:0] wdata;
    bit [31:0] misoWord;
    int        expLat;
    bit [31:0] expRdata;
    bit        expErr;
  } vecT;

  int checks = 0;
  int fails = 0;
  bit mosiQ[$];
  bit expQ[$];
  int sclkEdges = 0;
  int bitIdx = 0;
  int hdrBits = 32;
  bit [31:0] misoWord = 32'h0;
  bit prevSclk = 1'b0;

  // SPI device model: records MOSI in phase 1 and drives the data bytes on MISO.
  always @(negedge clk) begin : slave
    int d;
    if (cs0n && cs1n) begin
      bitIdx = 0;
    end else if (sclk) begin
      mosiQ.push_back(mosi);
      d = bitIdx - hdrBits;
      if (d >= 0 && d < 32) miso = misoWord[8 * (d / 8) + 7 - (d % 8)];
      else miso = 1'b0;
      bitIdx++;
    end
    if (sclk && !prevSclk) sclkEdges++;
    prevSclk = sclk;
  end

  function automatic int nBytes(input bit [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit isReject(input vecT v);
    return v.write && !v.sel;
  endfunction

  function automatic int totalBits(input vecT v);
    return 32 + ((FAST == 1 && !v.write) ? 8 : 0) + 8 * nBytes(v.size);
  endfunction

  function automatic int modelLat(input vecT v);
    return isReject(v) ? 1 : 1 + 2 * totalBits(v);
  endfunction

  function automatic bit [31:0] modelRdata(input vecT v);
    int n;
    n = nBytes(v.size);
    if (v.write) return 32'h0;
    if (n == 4) return v.misoWord;
    return v.misoWord & ((32'd1 << (8 * n)) - 32'd1);
  endfunction

  function automatic void buildExpMosi(input vecT v);
    bit [7:0] b[$];
    expQ.delete();
    if (isReject(v)) return;
    b.push_back(v.write ? 8'h02 : (FAST == 1 ? 8'h0B : 8'h03));
    b.push_back(v.addr[23:16]);
    b.push_back(v.addr[15:8]);
    b.push_back(v.addr[7:0]);
    if (FAST == 1 && !v.write) b.push_back(8'h00);
    for (int k = 0; k < nBytes(v.size); k++) b.push_back(v.write ? v.wdata[8 * k +: 8] : 8'h00);
    foreach (b[i]) for (int j = 7; j >= 0; j--) expQ.push_back(b[i][j]);
  endfunction

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Issues one request and follows it cycle by cycle until the response strobe.
  task automatic applyStimulus(input vecT v);
    int waitCnt, cyc, qStart, eStart, mism;
    bit csBad;
    logic selCs, otherCs;
    waitCnt = 0;
    while (bus.req_ready !== 1'b1 && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput({v.name, "_ready_before"}, {31'h0, bus.req_ready}, 32'h1);
    hdrBits = 32 + ((FAST == 1 && !v.write) ? 8 : 0);
    misoWord = v.misoWord;
    buildExpMosi(v);
    qStart = mosiQ.size();
    eStart = sclkEdges;
    bus.req_write = v.write;
    bus.req_sel   = v.sel;
    bus.req_size  = v.size;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = 24'($urandom);
    bus.req_wdata = $urandom;
    bus.req_size  = 2'($urandom);
    cyc = 1;
    csBad = 1'b0;
    while (bus.resp_valid !== 1'b1 && cyc < 400) begin
      selCs   = v.sel ? cs1n : cs0n;
      otherCs = v.sel ? cs0n : cs1n;
      if (otherCs !== 1'b1) csBad = 1'b1;
      if (isReject(v)) begin
        if (selCs !== 1'b1) csBad = 1'b1;
      end else if (selCs !== 1'b0) begin
        csBad = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    checkOutput({v.name, "_latency"}, cyc, v.expLat);
    checkOutput({v.name, "_rdata"}, bus.resp_rdata, v.expRdata);
    checkOutput({v.name, "_err"}, {31'h0, bus.resp_err}, {31'h0, v.expErr});
    checkOutput({v.name, "_cs_done"}, {30'h0, cs1n, cs0n}, 32'h3);
    checkOutput({v.name, "_cs_during"}, {31'h0, csBad}, 32'h0);
    checkOutput({v.name, "_sclk_edges"}, sclkEdges - eStart, isReject(v) ? 0 : totalBits(v));
    checkOutput({v.name, "_mosi_len"}, mosiQ.size() - qStart, expQ.size());
    mism = 0;
    foreach (expQ[i]) if (qStart + i >= mosiQ.size() || mosiQ[qStart + i] != expQ[i]) mism++;
    checkOutput({v.name, "_mosi_bits"}, mism, 0);
    @(negedge clk);
    checkOutput({v.name, "_ready_after"}, {31'h0, bus.req_ready}, 32'h1);
    checkOutput({v.name, "_strobe_1cyc"}, {31'h0, bus.resp_valid}, 32'h0);
  endtask

  vecT vecs[8];

  initial begin
    vecT v;
    int cyc, n, respCount, firstLow, gapStart, gap;
    bit sawResp, cs0Low;
    bit csHist[$];

    vecs[0] = '{"rd_word_ram",   1'b0, 1'b1, 2'd2, 24'h000100, 32'h0,        32'h44332211, 129 + F16, 32'h44332211, 1'b0};
    vecs[1] = '{"wr_half_ram",   1'b1, 1'b1, 2'd1, 24'h000010, 32'hDEADBEEF, 32'h0,        97,        32'h0,        1'b0};
    vecs[2] = '{"wr_flash",      1'b1, 1'b0, 2'd2, 24'h000020, 32'h01234567, 32'h0,        1,         32'h0,        1'b1};
    vecs[3] = '{"rd_byte_flash", 1'b0, 1'b0, 2'd0, 24'h000040, 32'h0,        32'hA5A5A580, 81 + F16,  32'h00000080, 1'b0};
    vecs[4] = '{"wr_word_ram",   1'b1, 1'b1, 2'd2, 24'hABCDEF, 32'h12345678, 32'h0,        129,       32'h0,        1'b0};
    vecs[5] = '{"wr_byte_ram",   1'b1, 1'b1, 2'd0, 24'h00FF01, 32'h000000C3, 32'h0,        81,        32'h0,        1'b0};
    vecs[6] = '{"rd_half_flash", 1'b0, 1'b0, 2'd1, 24'hFFFFFF, 32'h0,        32'hCAFEBABE, 97 + F16,  32'h0000BABE, 1'b0};
    vecs[7] = '{"rd_size3_ram",  1'b0, 1'b1, 2'd3, 24'h000003, 32'h0,        32'h01020304, 129 + F16, 32'h01020304, 1'b0};

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_sel   = 1'b0;
    bus.req_size  = 2'd0;
    bus.req_addr  = 24'h0;
    bus.req_wdata = 32'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_cs", {30'h0, cs1n, cs0n}, 32'h3);
    checkOutput("rst_sclk_mosi", {30'h0, sclk, mosi}, 32'h0);
    checkOutput("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    checkOutput("rst_resp_err", {31'h0, bus.resp_err}, 32'h0);
    checkOutput("rst_resp_rdata", bus.resp_rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_ready", {31'h0, bus.req_ready}, 32'h1);

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // Reset in the middle of a word read must abort without a response.
    misoWord = 32'h55AA55AA;
    hdrBits = 32 + FAST * 8;
    bus.req_write = 1'b0;
    bus.req_sel   = 1'b1;
    bus.req_size  = 2'd2;
    bus.req_addr  = 24'h000300;
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    cyc = 1;
    sawResp = 1'b0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.resp_valid) sawResp = 1'b1;
    end
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_cs", {30'h0, cs1n, cs0n}, 32'h3);
    checkOutput("midrst_sclk", {31'h0, sclk}, 32'h0);
    if (bus.resp_valid) sawResp = 1'b1;
    @(negedge clk);
    if (bus.resp_valid) sawResp = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    if (bus.resp_valid) sawResp = 1'b1;
    checkOutput("midrst_ready", {31'h0, bus.req_ready}, 32'h1);
    checkOutput("midrst_no_resp", {31'h0, sawResp}, 32'h0);
    v = '{"after_rst", 1'b0, 1'b1, 2'd2, 24'h000104, 32'h0, 32'h8899AABB, 129 + F16, 32'h8899AABB, 1'b0};
    applyStimulus(v);

    // Two reads with req_valid held high: chip select gap is DONE plus the accept cycle.
    misoWord = 32'h0BADF00D;
    hdrBits = 32 + FAST * 8;
    bus.req_write = 1'b0;
    bus.req_sel   = 1'b1;
    bus.req_size  = 2'd2;
    bus.req_addr  = 24'h000200;
    bus.req_valid = 1'b1;
    n = 0;
    respCount = 0;
    cs0Low = 1'b0;
    while (respCount < 2 && n < 600) begin
      @(negedge clk);
      n++;
      csHist.push_back(cs1n);
      if (!cs0n) cs0Low = 1'b1;
      if (bus.resp_valid) begin
        respCount++;
        checkOutput("b2b_rdata", bus.resp_rdata, 32'h0BADF00D);
        if (respCount == 2) bus.req_valid = 1'b0;
      end
    end
    checkOutput("b2b_resp_count", respCount, 2);
    checkOutput("b2b_cs0_idle", {31'h0, cs0Low}, 32'h0);
    firstLow = -1;
    gapStart = -1;
    gap = 0;
    foreach (csHist[i]) begin
      if (firstLow < 0) begin
        if (!csHist[i]) firstLow = i;
      end else if (gapStart < 0) begin
        if (csHist[i]) begin
          gapStart = i;
          gap = 1;
        end
      end else if (gap == i - gapStart && csHist[i]) begin
        gap++;
      end
    end
    checkOutput("b2b_cs_gap", gap, 2);
    @(negedge clk);
    checkOutput("b2b_ready_after", {31'h0, bus.req_ready}, 32'h1);

    // Randomized requests checked against the spec-level model.
    for (int i = 0; i < 20; i++) begin
      v.name     = $sformatf("rnd%0d", i);
      v.write    = 1'($urandom_range(0, 1));
      v.sel      = 1'($urandom_range(0, 1));
      v.size     = 2'($urandom_range(0, 3));
      v.addr     = 24'($urandom);
      v.wdata    = $urandom;
      v.misoWord = $urandom;
      v.expLat   = modelLat(v);
      v.expRdata = modelRdata(v);
      v.expErr   = isReject(v);
      applyStimulus(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
